// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters through a registered
// issue stage and per-port single-entry response buffers. Define ALU_ARB_RR_EN for round-robin ties.
module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid0,
  input  logic            req_valid1,
  output logic            req_ready0,
  output logic            req_ready1,
  input  logic [3:0]      req_sel0,
  input  logic [3:0]      req_sel1,
  input  logic [XLEN-1:0] req_a0,
  input  logic [XLEN-1:0] req_b0,
  input  logic [XLEN-1:0] req_a1,
  input  logic [XLEN-1:0] req_b1,
  output logic            rsp_valid0,
  output logic            rsp_valid1,
  input  logic            rsp_ready0,
  input  logic            rsp_ready1,
  output logic [XLEN-1:0] rsp_data0,
  output logic [XLEN-1:0] rsp_data1,
  output logic [3:0]      alu_sel,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  output logic            idle
);

  // Issue stage: the one operation currently presented to the shared ALU.
  logic                 r_e_valid;
  logic                 r_e_port;
  logic [3:0]           r_e_sel;
  logic [XLEN-1:0]      r_e_a;
  logic [XLEN-1:0]      r_e_b;

  logic [1:0]           r_rsp_valid;
  logic [1:0][XLEN-1:0] r_rsp_data;

  logic [1:0]           w_rsp_ready;
  logic [1:0]           w_req_valid;
  logic [1:0]           w_pop;
  logic [1:0]           w_capture;
  logic [1:0]           w_busy;
  logic [1:0]           w_elig;
  logic [1:0]           w_grant;
  logic                 w_tie_port;

  assign w_rsp_ready = {rsp_ready1, rsp_ready0};
  assign w_req_valid = {req_valid1, req_valid0};

  assign w_capture = {r_e_valid && r_e_port, r_e_valid && !r_e_port};
  assign w_pop     = r_rsp_valid & w_rsp_ready;

  // A port is free again in the very cycle its buffered result is popped.
  assign w_busy = w_capture | (r_rsp_valid & ~w_rsp_ready);
  assign w_elig = w_req_valid & ~w_busy & {2{!flush}};

`ifdef ALU_ARB_RR_EN
  // Tie-break history only exists in the build where it can influence a grant.
  logic r_last_grant;
  assign w_tie_port = ~r_last_grant;
`else
  assign w_tie_port = 1'b0;
`endif

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    w_grant = w_elig;
    if (w_elig == 2'b11) begin
      w_grant = w_tie_port ? 2'b10 : 2'b01;
    end
  end

  assign req_ready0 = w_grant[0];
  assign req_ready1 = w_grant[1];

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the response data registers are reset too, so rsp_data reads 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e_valid   <= 1'b0;
      r_e_port    <= 1'b0;
      r_e_sel     <= 4'b0000;
      r_e_a       <= '0;
      r_e_b       <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
`ifdef ALU_ARB_RR_EN
      r_last_grant <= 1'b1;
`endif
    end else if (flush) begin
      r_e_valid   <= 1'b0;
      r_rsp_valid <= 2'b00;
    end else begin
      r_e_valid <= |w_grant;
      if (|w_grant) begin
        r_e_port <= w_grant[1];
        r_e_sel  <= w_grant[1] ? req_sel1 : req_sel0;
        r_e_a    <= w_grant[1] ? req_a1   : req_a0;
        r_e_b    <= w_grant[1] ? req_b1   : req_b0;
`ifdef ALU_ARB_RR_EN
        r_last_grant <= w_grant[1];
`endif
      end
      for (int p = 0; p < 2; p++) begin
        // Capture beats pop: the buffer stays valid and takes the new result.
        if (w_capture[p]) begin
          r_rsp_valid[p] <= 1'b1;
          r_rsp_data[p]  <= alu_result;
        end else if (w_pop[p]) begin
          r_rsp_valid[p] <= 1'b0;
        end
      end
    end
  end

  assign alu_sel    = r_e_sel;
  assign alu_a      = r_e_a;
  assign alu_b      = r_e_b;

  assign rsp_valid0 = r_rsp_valid[0];
  assign rsp_valid1 = r_rsp_valid[1];
  assign rsp_data0  = r_rsp_data[0];
  assign rsp_data1  = r_rsp_data[1];

  assign idle = !r_e_valid && (r_rsp_valid == 2'b00);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, hand-written multi-cycle
// sequences and randomized traffic, all checked against a transaction-level reference model.
module tb_alu_share_arbiter;

  localparam int XLEN = 32;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SLT = 4'd7;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, flush;
  logic            req_valid0, req_valid1, req_ready0, req_ready1;
  logic [3:0]      req_sel0, req_sel1;
  logic [XLEN-1:0] req_a0, req_b0, req_a1, req_b1;
  logic            rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
  logic [XLEN-1:0] rsp_data0, rsp_data1;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] alu_a, alu_b, alu_result;
  logic            idle;

  always #5 clk = ~clk;

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_sel0(req_sel0), .req_sel1(req_sel1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .idle(idle)
  );

  // Stand-in for the shared combinational ALU.
  function automatic logic [31:0] alu_fn(input logic [3:0] sel, input logic [31:0] a,
                                         input logic [31:0] b);
    case (sel)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_sel, alu_a, alu_b);

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_g = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each port owns at most one accepted operation, tagged with its accept cycle.
  // It is visible as a response from accept+2 until popped; it drives the ALU during accept+1.
  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a, b, res;
    int          acc;
  } op_t;

  bit          m_has [2];
  op_t         m_op [2];
  logic [31:0] m_shown [2];
  logic [3:0]  m_alu_sel;
  logic [31:0] m_alu_a, m_alu_b;
  int          m_last;

  task automatic model_reset();
    m_has     = '{1'b0, 1'b0};
    m_shown   = '{32'd0, 32'd0};
    m_alu_sel = 4'd0;
    m_alu_a   = 32'd0;
    m_alu_b   = 32'd0;
    m_last    = 1;
  endtask

  // One clock cycle: inputs are already applied; compare at the falling edge, advance at rising.
  task automatic cycle();
    bit          vis [2];
    bit          busy [2];
    bit          elig [2];
    bit          rv [2];
    bit          rr [2];
    logic [3:0]  sel [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    bit          idle_e;
    int          g;
    @(negedge clk);
    rv  = '{req_valid0, req_valid1};
    rr  = '{rsp_ready0, rsp_ready1};
    sel = '{req_sel0, req_sel1};
    a   = '{req_a0, req_a1};
    b   = '{req_b0, req_b1};
    idle_e = 1'b1;
    for (int p = 0; p < 2; p++) begin
      vis[p] = m_has[p] && (cyc >= m_op[p].acc + 2);
      if (m_has[p] && cyc == m_op[p].acc + 2) m_shown[p] = m_op[p].res;
      if (m_has[p] && cyc == m_op[p].acc + 1) begin
        m_alu_sel = m_op[p].sel;
        m_alu_a   = m_op[p].a;
        m_alu_b   = m_op[p].b;
      end
      if (m_has[p] && m_op[p].acc < cyc) idle_e = 1'b0;
      busy[p] = m_has[p] && !(vis[p] && rr[p]);
      elig[p] = rv[p] && !busy[p] && !flush;
    end
    g = -1;
    if (elig[0] && elig[1]) g = (RR && m_last == 0) ? 1 : 0;
    else if (elig[0])       g = 0;
    else if (elig[1])       g = 1;
    check("req_ready0", req_ready0, g == 0);
    check("req_ready1", req_ready1, g == 1);
    check("rsp_valid0", rsp_valid0, vis[0]);
    check("rsp_valid1", rsp_valid1, vis[1]);
    check("rsp_data0",  rsp_data0,  m_shown[0]);
    check("rsp_data1",  rsp_data1,  m_shown[1]);
    check("alu_sel",    alu_sel,    m_alu_sel);
    check("alu_a",      alu_a,      m_alu_a);
    check("alu_b",      alu_b,      m_alu_b);
    check("idle",       idle,       idle_e);
    last_g = g;
    @(posedge clk);
    if (flush) begin
      m_has = '{1'b0, 1'b0};
    end else begin
      for (int p = 0; p < 2; p++) if (vis[p] && rr[p]) m_has[p] = 1'b0;
      if (g >= 0) begin
        m_has[g] = 1'b1;
        m_op[g]  = '{sel[g], a[g], b[g], alu_fn(sel[g], a[g], b[g]), cyc};
        m_last   = g;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    req_valid0 = 1'b0; req_valid1 = 1'b0; flush = 1'b0;
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (4) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready0"}, req_ready0, 1'b0);
    check({tag, "_ready1"}, req_ready1, 1'b0);
    check({tag, "_rvalid0"}, rsp_valid0, 1'b0);
    check({tag, "_rvalid1"}, rsp_valid1, 1'b0);
    check({tag, "_rdata0"}, rsp_data0, 32'd0);
    check({tag, "_rdata1"}, rsp_data1, 32'd0);
    check({tag, "_alu_sel"}, alu_sel, 4'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_idle"}, idle, 1'b1);
  endtask

  typedef struct {
    int          port;
    logic [3:0]  sel;
    logic [31:0] a, b, exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  int   grants [8];
  int   exp_cont [4];
  int   exp_bp0 [6];
  int   exp_tp [6];

  initial begin
    vecs[0] = '{0, ALU_ADD, 32'd5,          32'd7,          32'd12};
    vecs[1] = '{0, ALU_SUB, 32'd10,         32'd3,          32'd7};
    vecs[2] = '{1, ALU_XOR, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0};
    vecs[3] = '{1, ALU_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF};
    vecs[4] = '{0, ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[5] = '{1, ALU_SLL, 32'd1,          32'd31,         32'h8000_0000};
    vecs[6] = '{0, ALU_SRL, 32'h8000_0000,  32'd31,         32'd1};
    vecs[7] = '{0, ALU_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
    vecs[8] = '{0, ALU_OR,  32'h1200_0000,  32'h0000_0034,  32'h1200_0034};
    vecs[9] = '{1, ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1};
    exp_cont = '{0, 1, 0, 1};
    exp_bp0  = '{0, 1, -1, 1, -1, 1};
    exp_tp   = '{0, -1, 0, -1, 0, -1};

    rst = 1'b1;
    idle_inputs();
    req_sel0 = 4'd0; req_sel1 = 4'd0;
    req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Directed single operations, response held until explicitly checked.
    for (int i = 0; i < NV; i++) begin
      rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
      if (vecs[i].port == 0) begin
        req_valid0 = 1'b1; req_sel0 = vecs[i].sel; req_a0 = vecs[i].a; req_b0 = vecs[i].b;
      end else begin
        req_valid1 = 1'b1; req_sel1 = vecs[i].sel; req_a1 = vecs[i].a; req_b1 = vecs[i].b;
      end
      #1;
      check("vec_ready", (vecs[i].port == 0) ? req_ready0 : req_ready1, 1'b1);
      cycle();
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      cycle();
      check("vec_rsp_valid", (vecs[i].port == 0) ? rsp_valid0 : rsp_valid1, 1'b1);
      check("vec_rsp_data",  (vecs[i].port == 0) ? rsp_data0  : rsp_data1,  vecs[i].exp);
      rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      cycle();
    end
    drain();

    // Contention: both ports requesting every cycle, responses consumed immediately.
    req_valid0 = 1'b1; req_sel0 = ALU_SUB; req_a0 = 32'd10;  req_b0 = 32'd3;
    req_valid1 = 1'b1; req_sel1 = ALU_XOR; req_a1 = 32'hFF;  req_b1 = 32'h0F;
    for (int i = 0; i < 8; i++) begin
      cycle();
      grants[i] = last_g;
    end
    for (int i = 0; i < 4; i++) check("contention_grant", grants[i], exp_cont[i]);
    drain();

    // Port 0 never consumes: after its first grant, port 1 takes every grant.
    req_valid0 = 1'b1; req_valid1 = 1'b1; rsp_ready0 = 1'b0; rsp_ready1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("stall0_grant", last_g, exp_bp0[i]);
    end
    drain();

    // Backpressure on port 1 for five cycles after its result lands.
    req_valid1 = 1'b1; req_sel1 = ALU_ADD; req_a1 = 32'd100; req_b1 = 32'd23; rsp_ready1 = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid1", rsp_valid1, 1'b1);
      check("bp_rsp_data1",  rsp_data1,  32'd123);
      check("bp_req_ready1", req_ready1, 1'b0);
      cycle();
    end
    rsp_ready1 = 1'b1;
    #1;
    check("bp_release_ready1", req_ready1, 1'b1);
    cycle();
    drain();

    // Single-port throughput: accept, gap, accept with rsp_ready held high.
    req_valid0 = 1'b1; req_sel0 = ALU_ADD; req_a0 = 32'd1; req_b0 = 32'd2;
    for (int i = 0; i < 6; i++) begin
      req_a0 = 32'(i + 1);
      cycle();
      check("tput_grant", last_g, exp_tp[i]);
    end
    drain();

    // Flush with one op buffered on port 0 and one in the issue stage for port 1.
    rsp_ready0 = 1'b0; rsp_ready1 = 1'b0;
    req_valid0 = 1'b1; req_sel0 = ALU_ADD; req_a0 = 32'd1; req_b0 = 32'd2;
    cycle();
    req_valid0 = 1'b0;
    req_valid1 = 1'b1; req_sel1 = ALU_SUB; req_a1 = 32'd9; req_b1 = 32'd4;
    cycle();
    req_valid1 = 1'b0; flush = 1'b1;
    check("flush_pre_valid0", rsp_valid0, 1'b1);
    check("flush_pre_idle", idle, 1'b0);
    cycle();
    flush = 1'b0;
    check("flush_post_valid0", rsp_valid0, 1'b0);
    check("flush_post_valid1", rsp_valid1, 1'b0);
    check("flush_post_idle", idle, 1'b1);
    rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("flush_no_rsp", {rsp_valid1, rsp_valid0}, 2'b00);
    end
    flush = 1'b1; req_valid0 = 1'b1; req_valid1 = 1'b1;
    #1;
    check("flush_no_grant", {req_ready1, req_ready0}, 2'b00);
    cycle();
    drain();

    // Asynchronous reset while an op sits in the issue stage.
    req_valid0 = 1'b1; req_sel0 = ALU_ADD; req_a0 = 32'd40; req_b0 = 32'd2;
    cycle();
    req_valid0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    #1;
    check("post_rst_tie0", req_ready0, 1'b1);
    check("post_rst_tie1", req_ready1, 1'b0);
    cycle();
    check("post_rst_grant", last_g, 0);
    drain();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      req_valid0 = ($urandom_range(9) < 7);
      req_valid1 = ($urandom_range(9) < 7);
      rsp_ready0 = ($urandom_range(9) < 6);
      rsp_ready1 = ($urandom_range(9) < 6);
      flush      = ($urandom_range(31) == 0);
      req_sel0   = 4'($urandom_range(7));
      req_sel1   = 4'($urandom_range(7));
      req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
